fp_sqrt_arbiter: RTL and testbench
==================================

Name: fp_sqrt_arbiter

Overview:
- Shares one pipelined fp-sqrt wrapper between NUM_CORES requesters using round-robin arbitration.
- Tags each issued operation with the requester index.
- Captures each returning result into a per-requester result slot and holds it until the requester accepts it.
- Sits between the core-side APU request ports and the sqrt unit's En/OpA/Rnd/Tag inputs and Res/Status/Tag/Valid outputs.

Parameters:
- NUM_CORES, 4, number of requesters (≥2)
- FP_WIDTH, 32, operand/result width
- RND_WIDTH, 3, rounding-mode width
- STAT_WIDTH, 8, status-flag width
- TAG_WIDTH, $clog2(NUM_CORES), tag width toward the unit

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- Req_i  in  NUM_CORES  per-core request
- OpA_i  in  NUM_CORES x FP_WIDTH  per-core operand
- Rnd_i  in  NUM_CORES x RND_WIDTH  per-core rounding mode
- Gnt_o  out  NUM_CORES  per-core grant, combinational, at most one hot
- RValid_o  out  NUM_CORES  per-core result valid, registered
- Res_o  out  NUM_CORES x FP_WIDTH  per-core result slot
- Status_o  out  NUM_CORES x STAT_WIDTH  per-core status slot
- RReady_i  in  NUM_CORES  per-core result accept
- En_o  out  1  issue strobe to the unit
- OpA_o  out  FP_WIDTH  operand to the unit
- Rnd_o  out  RND_WIDTH  rounding mode to the unit
- Tag_o  out  TAG_WIDTH  tag (winner index) to the unit
- Ready_i  in  1  unit ready
- Valid_i  in  1  unit result valid
- Res_i  in  FP_WIDTH  unit result
- Status_i  in  STAT_WIDTH  unit status
- Tag_i  in  TAG_WIDTH  unit returned tag

Behaviour:
- Reset:
  - Gnt_o, RValid_o, Res_o, Status_o, En_o all 0.
  - Round-robin pointer = 0.
  - Busy[] = 0.
- Eligibility: eligible[k] = Req_i[k] & ~Busy[k]. No grant when Ready_i = 0.
- Arbitration:
  - Winner = first eligible index searching from the pointer upward, wrapping NUM_CORES-1 → 0.
  - Gnt_o[winner] = 1 in the same cycle as the request.
  - En_o = |Gnt_o.
  - OpA_o, Rnd_o, Tag_o are muxed from the winner. OpA_o, Rnd_o and Tag_o are 0 when En_o = 0.
- Pointer: on a grant, pointer ← (winner+1) mod NUM_CORES. With no grant it holds.
- Busy tracking:
  - Busy[k] sets on the clock edge after Gnt_o[k].
  - Busy[k] clears on the edge where RValid_o[k] & RReady_i[k].
  - Result: at most one operation in flight or held per core.
  - A core whose result is accepted in cycle t is eligible again from cycle t+1, not in cycle t.
- Result capture:
  - When Valid_i = 1, slot[Tag_i] ← {Res_i, Status_i} and RValid_o[Tag_i] ← 1 at the next edge.
  - Res_o and Status_o hold until accept. RValid_o clears at the accept edge.
- Latency, with unit pipe depth L: grant at cycle 0, Valid_i at cycle L, RValid_o visible at cycle L+1.
  - With L = 0: grant and result in the same cycle, RValid_o visible at cycle 1.
- Simultaneous events:
  - Grant to core j and result capture for core k in the same cycle are independent and both occur.
  - An accept for core k and a new capture cannot coincide: Busy guarantees the slot is empty.
- Tag/slot rule: Valid_i with Tag_i ≥ NUM_CORES, or with RValid_o[Tag_i] already 1, is a protocol violation.
  - The bench flags it with an assertion.
  - RTL overwrites the slot.
- Requester protocol: a requester keeps Req_i, OpA_i and Rnd_i stable until Gnt_o. It may drop Req_i before grant with no side effect.
- Reset mid-operation: all state clears asynchronously. In-flight unit results arriving after reset are not captured unless their tag's slot state permits; the unit is reset on the same rst_ni, so none arrive.

Test Plan (NUM_CORES=4, unit L=2):
- Single request: Req_i[2]=1, OpA=0x40800000 (4.0) at cycle 0 → Gnt_o=0b0100 at cycle 0, Tag_o=2, RValid_o[2]=1 at cycle 3 with Res_o[2]=0x40000000.
- All four requesting continuously from reset → grants in order 0,1,2,3, one per cycle. No core is re-granted before its result is accepted.
- Back-pressure: core 1 holds RReady_i=0 for 10 cycles → RValid_o[1] and Res_o[1] held stable; Gnt_o[1]=0 throughout. Accept at cycle t → re-grant possible at t+1.
- Out-of-order accepts: cores 0 and 3 granted consecutively, core 3 accepts first → each slot returns its own tag's result, no cross-talk.
- Ready_i=0 while Req_i=0b1111 → Gnt_o=0, En_o=0, pointer unchanged. Ready_i rises → grant goes to the current pointer index.
- Assert rst_ni=0 with two results held → RValid_o=0, Busy cleared, pointer=0. After release, a new request is granted immediately.

Source files
------------

// File: rtl/fp_sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_sqrt_arbiter
// Description : Shares one pipelined floating-point square-root unit between
//               NUM_CORES requesters using round-robin arbitration. Each
//               issued operation is tagged with the requester index. The
//               returning result is parked in that requester's result slot
//               until the requester accepts it. A requester has at most one
//               operation in flight or held at any time.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i     in   clock
//   rst_ni    in   asynchronous active-low reset
//   Req_i     in   per-core request
//   OpA_i     in   per-core operand
//   Rnd_i     in   per-core rounding mode
//   Gnt_o     out  per-core grant (combinational, at most one hot)
//   RValid_o  out  per-core result valid (registered)
//   Res_o     out  per-core result slot
//   Status_o  out  per-core status slot
//   RReady_i  in   per-core result accept
//   En_o      out  issue strobe to the unit
//   OpA_o     out  operand to the unit
//   Rnd_o     out  rounding mode to the unit
//   Tag_o     out  tag (winner index) to the unit
//   Ready_i   in   unit ready
//   Valid_i   in   unit result valid
//   Res_i     in   unit result
//   Status_i  in   unit status
//   Tag_i     in   unit returned tag
// ============================================================================
module fp_sqrt_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int FP_WIDTH   = 32,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 8,
    parameter int TAG_WIDTH  = $clog2(NUM_CORES)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_CORES-1:0]                  Req_i,
    input  logic [NUM_CORES-1:0][FP_WIDTH-1:0]    OpA_i,
    input  logic [NUM_CORES-1:0][RND_WIDTH-1:0]   Rnd_i,
    output logic [NUM_CORES-1:0]                  Gnt_o,
    output logic [NUM_CORES-1:0]                  RValid_o,
    output logic [NUM_CORES-1:0][FP_WIDTH-1:0]    Res_o,
    output logic [NUM_CORES-1:0][STAT_WIDTH-1:0]  Status_o,
    input  logic [NUM_CORES-1:0]                  RReady_i,
    output logic                                  En_o,
    output logic [FP_WIDTH-1:0]                   OpA_o,
    output logic [RND_WIDTH-1:0]                  Rnd_o,
    output logic [TAG_WIDTH-1:0]                  Tag_o,
    input  logic                                  Ready_i,
    input  logic                                  Valid_i,
    input  logic [FP_WIDTH-1:0]                   Res_i,
    input  logic [STAT_WIDTH-1:0]                 Status_i,
    input  logic [TAG_WIDTH-1:0]                  Tag_i
);

    localparam logic [TAG_WIDTH-1:0] c_LAST_IDX = TAG_WIDTH'(NUM_CORES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [TAG_WIDTH-1:0]                  r_ptr;
    logic [NUM_CORES-1:0]                  r_busy;
    logic [NUM_CORES-1:0]                  r_rvalid;
    logic [NUM_CORES-1:0][FP_WIDTH-1:0]    r_res;
    logic [NUM_CORES-1:0][STAT_WIDTH-1:0]  r_status;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [NUM_CORES-1:0]  w_elig;
    logic                  w_found;
    logic [TAG_WIDTH-1:0]  w_winner;
    logic [NUM_CORES-1:0]  w_gnt;
    logic [FP_WIDTH-1:0]   w_opa;
    logic [RND_WIDTH-1:0]  w_rnd;
    logic [TAG_WIDTH-1:0]  w_ptr_nxt;
    logic [NUM_CORES-1:0]  w_cap;
    logic [NUM_CORES-1:0]  w_acc;

    // Busy covers both in-flight and held results, so a core waiting on its
    // own slot can never be granted again.
    assign w_elig = Req_i & ~r_busy & {NUM_CORES{Ready_i}};

    // Round-robin search without modulo arithmetic: first pass looks only at
    // indices at or above the pointer, second pass covers the wrap-around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && w_elig[i] && (TAG_WIDTH'(i) >= r_ptr)) begin
                w_found  = 1'b1;
                w_winner = TAG_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && w_elig[i]) begin
                w_found  = 1'b1;
                w_winner = TAG_WIDTH'(i);
            end
        end
    end

    // One-hot grant and operand mux; everything toward the unit is zero
    // when nothing is issued.
    always_comb begin
        w_gnt = '0;
        w_opa = '0;
        w_rnd = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_gnt[i] = w_found && (w_winner == TAG_WIDTH'(i));
            if (w_gnt[i]) begin
                w_opa = OpA_i[i];
                w_rnd = Rnd_i[i];
            end
        end
    end

    assign w_ptr_nxt = (w_winner == c_LAST_IDX) ? '0 : (w_winner + TAG_WIDTH'(1));

    // Result capture is steered by the returned tag; an out-of-range tag
    // matches no slot and is dropped.
    always_comb begin
        w_cap = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_cap[i] = Valid_i && (Tag_i == TAG_WIDTH'(i));
        end
    end

    assign w_acc = r_rvalid & RReady_i;

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr    <= '0;
            r_busy   <= '0;
            r_rvalid <= '0;
            r_res    <= '0;
            r_status <= '0;
        end else begin
            if (w_found) begin
                r_ptr <= w_ptr_nxt;
            end
            // A grant only goes to a non-busy core and an accept only happens
            // on a busy one, so set and clear never target the same bit.
            r_busy   <= (r_busy | w_gnt) & ~w_acc;
            // A capture onto an already-valid slot overwrites it.
            r_rvalid <= w_cap | (r_rvalid & ~w_acc);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_cap[i]) begin
                    r_res[i]    <= Res_i;
                    r_status[i] <= Status_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Gnt_o    = w_gnt;
    assign En_o     = |w_gnt;
    assign OpA_o    = w_opa;
    assign Rnd_o    = w_rnd;
    assign Tag_o    = w_found ? w_winner : '0;
    assign RValid_o = r_rvalid;
    assign Res_o    = r_res;
    assign Status_o = r_status;

endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_sqrt_arbiter
// Description : Directed bench for fp_sqrt_arbiter with a two-stage sqrt
//               unit model (lookup of exact square roots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_sqrt_arbiter;

    logic              clk;
    logic              rst_n;
    logic [3:0]        Req_i;
    logic [3:0][31:0]  OpA_i;
    logic [3:0][2:0]   Rnd_i;
    logic [3:0]        Gnt_o;
    logic [3:0]        RValid_o;
    logic [3:0][31:0]  Res_o;
    logic [3:0][7:0]   Status_o;
    logic [3:0]        RReady_i;
    logic              En_o;
    logic [31:0]       OpA_o;
    logic [2:0]        Rnd_o;
    logic [1:0]        Tag_o;
    logic              Ready_i;
    logic              Valid_i;
    logic [31:0]       Res_i;
    logic [7:0]        Status_i;
    logic [1:0]        Tag_i;

    int checks   = 0;
    int failures = 0;

    fp_sqrt_arbiter #(
        .NUM_CORES (4),
        .FP_WIDTH  (32),
        .RND_WIDTH (3),
        .STAT_WIDTH(8),
        .TAG_WIDTH (2)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .Req_i   (Req_i),
        .OpA_i   (OpA_i),
        .Rnd_i   (Rnd_i),
        .Gnt_o   (Gnt_o),
        .RValid_o(RValid_o),
        .Res_o   (Res_o),
        .Status_o(Status_o),
        .RReady_i(RReady_i),
        .En_o    (En_o),
        .OpA_o   (OpA_o),
        .Rnd_o   (Rnd_o),
        .Tag_o   (Tag_o),
        .Ready_i (Ready_i),
        .Valid_i (Valid_i),
        .Res_i   (Res_i),
        .Status_i(Status_i),
        .Tag_i   (Tag_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Sqrt unit model, pipe depth 2, exact roots of a few perfect squares
    // ------------------------------------------------------------------------
    function automatic logic [31:0] sqrt_lut(input logic [31:0] x);
        case (x)
            32'h3F800000: sqrt_lut = 32'h3F800000; // 1  -> 1
            32'h40800000: sqrt_lut = 32'h40000000; // 4  -> 2
            32'h41100000: sqrt_lut = 32'h40400000; // 9  -> 3
            32'h41800000: sqrt_lut = 32'h40800000; // 16 -> 4
            32'h42800000: sqrt_lut = 32'h41000000; // 64 -> 8
            default:      sqrt_lut = 32'h7FC00000;
        endcase
    endfunction

    logic        s1_v, s2_v;
    logic [1:0]  s1_t, s2_t;
    logic [31:0] s1_op, s2_op;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s2_v <= 1'b0;
            s1_t <= '0;   s2_t <= '0;
            s1_op <= '0;  s2_op <= '0;
        end else begin
            s1_v <= En_o;  s1_t <= Tag_o; s1_op <= OpA_o;
            s2_v <= s1_v;  s2_t <= s1_t;  s2_op <= s1_op;
        end
    end

    assign Valid_i  = s2_v;
    assign Tag_i    = s2_t;
    assign Res_i    = sqrt_lut(s2_op);
    assign Status_i = {6'b101000, s2_t};

    // ------------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A result must never land on a slot that is still holding one.
    always @(negedge clk) begin
        if (rst_n && Valid_i) begin
            checks++;
            assert (RValid_o[Tag_i] === 1'b0) else begin
                failures++;
                $error("FAIL slot_overwrite observed=%0h expected=0", RValid_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        Req_i    = '0;
        OpA_i    = '0;
        Rnd_i    = '0;
        RReady_i = '0;
        Ready_i  = 1'b1;
        #2;
        chk("rst_gnt",    64'(Gnt_o),    64'h0);
        chk("rst_en",     64'(En_o),     64'h0);
        chk("rst_rvalid", 64'(RValid_o), 64'h0);
        chk("rst_res",    64'(Res_o[2]), 64'h0);
        chk("rst_status", 64'(Status_o), 64'h0);
        step();
        step();
        rst_n = 1'b1;

        // ---- single request on core 2 ----
        step();
        Req_i = 4'b0100; OpA_i[2] = 32'h40800000; Rnd_i[2] = 3'd1;
        settle();
        chk("single_gnt",  64'(Gnt_o), 64'h4);
        chk("single_en",   64'(En_o),  64'h1);
        chk("single_tag",  64'(Tag_o), 64'h2);
        chk("single_opa",  64'(OpA_o), 64'h40800000);
        chk("single_rnd",  64'(Rnd_o), 64'h1);
        step(); Req_i = 4'b0000; settle();
        chk("single_rv_c1", 64'(RValid_o), 64'h0);
        step();
        chk("single_rv_c2", 64'(RValid_o), 64'h0);
        step();
        chk("single_rv_c3", 64'(RValid_o), 64'h4);
        chk("single_res",   64'(Res_o[2]), 64'h40000000);
        chk("single_stat",  64'(Status_o[2]), 64'hA2);
        // accept and re-request in the same cycle: not yet eligible
        Req_i = 4'b0100; RReady_i = 4'b0100; OpA_i[2] = 32'h41800000;
        settle();
        chk("accept_same_cycle_gnt", 64'(Gnt_o), 64'h0);
        step(); RReady_i = 4'b0000; settle();
        chk("accept_rv_cleared", 64'(RValid_o), 64'h0);
        chk("regrant_next_cycle", 64'(Gnt_o), 64'h4);
        step(); Req_i = 4'b0000;
        step();
        step(); settle();
        chk("regrant_res", 64'(Res_o[2]), 64'h40800000);
        RReady_i = 4'b0100;
        step(); RReady_i = 4'b0000; settle();
        chk("regrant_acc", 64'(RValid_o), 64'h0);

        // ---- round robin from reset ----
        rst_n = 1'b0;
        settle();
        chk("midrst_rvalid", 64'(RValid_o), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        Req_i = 4'b1111;
        OpA_i[0] = 32'h3F800000; OpA_i[1] = 32'h40800000;
        OpA_i[2] = 32'h41100000; OpA_i[3] = 32'h42800000;
        settle();
        chk("rr_gnt0", 64'(Gnt_o), 64'h1);
        chk("rr_tag0", 64'(Tag_o), 64'h0);
        step(); settle();
        chk("rr_gnt1", 64'(Gnt_o), 64'h2);
        chk("rr_tag1", 64'(Tag_o), 64'h1);
        step(); settle();
        chk("rr_gnt2", 64'(Gnt_o), 64'h4);
        step(); settle();
        chk("rr_gnt3", 64'(Gnt_o), 64'h8);
        chk("rr_tag3", 64'(Tag_o), 64'h3);
        chk("rr_rv_b3", 64'(RValid_o), 64'h1);
        step(); settle();
        chk("rr_all_busy_b4", 64'(Gnt_o), 64'h0);
        step(); settle();
        chk("rr_all_busy_b5", 64'(Gnt_o), 64'h0);
        step(); settle();
        chk("rr_rv_all", 64'(RValid_o), 64'hF);
        chk("rr_res0", 64'(Res_o[0]), 64'h3F800000);
        chk("rr_res1", 64'(Res_o[1]), 64'h40000000);
        chk("rr_res2", 64'(Res_o[2]), 64'h40400000);
        chk("rr_res3", 64'(Res_o[3]), 64'h41000000);
        chk("rr_stat1", 64'(Status_o[1]), 64'hA1);
        chk("rr_no_regrant", 64'(Gnt_o), 64'h0);

        // ---- back-pressure on core 1 ----
        Req_i = 4'b0010; RReady_i = 4'b1101;
        step(); RReady_i = 4'b0000; OpA_i[1] = 32'h41100000; settle();
        for (int i = 0; i < 10; i++) begin
            chk("bp_gnt",    64'(Gnt_o),    64'h0);
            chk("bp_rvalid", 64'(RValid_o), 64'h2);
            chk("bp_res",    64'(Res_o[1]), 64'h40000000);
            step(); settle();
        end
        RReady_i = 4'b0010; settle();
        chk("bp_accept_same_cycle", 64'(Gnt_o), 64'h0);
        step(); RReady_i = 4'b0000; settle();
        chk("bp_rv_cleared", 64'(RValid_o), 64'h0);
        chk("bp_regrant", 64'(Gnt_o), 64'h2);
        step(); Req_i = 4'b0000;
        step();
        step(); settle();
        chk("bp_new_res", 64'(Res_o[1]), 64'h40400000);

        // ---- out-of-order accepts, cores 3 then 0 (pointer at 2) ----
        Req_i = 4'b1001; OpA_i[0] = 32'h41800000; OpA_i[3] = 32'h3F800000;
        settle();
        chk("ooo_gnt3", 64'(Gnt_o), 64'h8);
        step(); Req_i = 4'b0001; settle();
        chk("ooo_gnt0", 64'(Gnt_o), 64'h1);
        chk("ooo_tag0", 64'(Tag_o), 64'h0);
        step(); Req_i = 4'b0000;
        step(); settle();
        chk("ooo_rv_c3", 64'(RValid_o), 64'hA);
        chk("ooo_res3",  64'(Res_o[3]), 64'h3F800000);
        chk("ooo_stat3", 64'(Status_o[3]), 64'hA3);
        step(); settle();
        chk("ooo_rv_c4", 64'(RValid_o), 64'hB);
        chk("ooo_res0",  64'(Res_o[0]), 64'h40800000);
        RReady_i = 4'b1000;
        step(); RReady_i = 4'b0000; settle();
        chk("ooo_rv_c5", 64'(RValid_o), 64'h3);
        chk("ooo_res0_held", 64'(Res_o[0]), 64'h40800000);
        chk("ooo_res1_held", 64'(Res_o[1]), 64'h40400000);

        // ---- unit not ready (pointer at 1) ----
        Req_i = 4'b1100; Ready_i = 1'b0; OpA_i[2] = 32'h42800000;
        settle();
        chk("nr_gnt", 64'(Gnt_o), 64'h0);
        chk("nr_en",  64'(En_o),  64'h0);
        chk("nr_opa", 64'(OpA_o), 64'h0);
        chk("nr_tag", 64'(Tag_o), 64'h0);
        step(); settle();
        chk("nr_gnt_hold", 64'(Gnt_o), 64'h0);
        step(); Ready_i = 1'b1; settle();
        chk("nr_ready_gnt", 64'(Gnt_o), 64'h4);
        chk("nr_ready_opa", 64'(OpA_o), 64'h42800000);

        // ---- reset with results held and one in flight ----
        step(); Req_i = 4'b0000; settle();
        rst_n = 1'b0;
        settle();
        chk("rst_held_rvalid", 64'(RValid_o), 64'h0);
        chk("rst_held_res",    64'(Res_o),    64'h0);
        step();
        step();
        rst_n = 1'b1; Req_i = 4'b1111;
        settle();
        chk("post_rst_gnt0", 64'(Gnt_o), 64'h1);
        step(); settle();
        chk("post_rst_gnt1", 64'(Gnt_o), 64'h2);
        step(); Req_i = 4'b0000;
        step();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
